// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = DIV_IDLE,
        S_CALC = DIV_CALC,
        S_FIX  = DIV_FIX,
        S_DONE = DIV_DONE
    } div_state_e;

    // Two's complement magnitude; 0x80000000 maps onto itself and is
    // then treated as an unsigned value by the divider core.
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? (~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    // Conditional negation used for the final sign fix-up.
    function automatic logic [DIV_WIDTH-1:0] div_neg_if(input logic [DIV_WIDTH-1:0] x,
                                                        input logic                 neg);
        return neg ? (~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Trial subtraction is one bit wider than the operands; its MSB is the borrow.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next = diff_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient feeds LO, remainder feeds HI.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DIV_START,
    input  logic             DIV_SIGNED,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             DIV_BUSY,
    output logic             DIV_DONE,
    output logic [WIDTH-1:0] DIV_Q,
    output logic [WIDTH-1:0] DIV_R,
    output logic             DIV_BY_ZERO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_r;
    div_state_e       state_s;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvd_raw_r;
    logic             sign_q_r;
    logic             sign_rem_r;
    logic             zero_r;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             bz_r;
    logic             busy_r;
    logic             done_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a start is only honoured in IDLE or DONE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (DIV_START) begin
                    accept_s = 1'b1;
                    state_s  = S_CALC;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_FIX: begin
                state_s = S_DONE;
            end
            S_DONE: begin
                if (DIV_START) begin
                    accept_s = 1'b1;
                    state_s  = S_CALC;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one restoring step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            dvs_r      <= '0;
            dvd_raw_r  <= '0;
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            zero_r     <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= CNT_W'(WIDTH);
            rem_r      <= '0;
            quo_r      <= DIV_SIGNED ? div_abs(DIVIDEND) : DIVIDEND;
            dvs_r      <= DIV_SIGNED ? div_abs(DIVISOR) : DIVISOR;
            dvd_raw_r  <= DIVIDEND;
            sign_q_r   <= DIV_SIGNED & (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
            sign_rem_r <= DIV_SIGNED & DIVIDEND[WIDTH-1];
            zero_r     <= (DIVISOR == '0);
        end else if (state_r == S_CALC) begin
            cnt_r <= cnt_r - CNT_W'(1);
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
        end
    end

    // Result registers update only in FIX; status flags follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            r_r    <= '0;
            bz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == S_CALC) || (state_s == S_FIX);
            done_r <= (state_s == S_DONE);
            if (state_r == S_FIX) begin
                bz_r <= zero_r;
                if (zero_r) begin
                    // Divide by zero: sign fix-up is bypassed, dividend returned raw.
                    q_r <= {WIDTH{1'b1}};
                    r_r <= dvd_raw_r;
                end else begin
                    q_r <= div_neg_if(quo_r, sign_q_r);
                    r_r <= div_neg_if(rem_r, sign_rem_r);
                end
            end
        end
    end

    assign DIV_BUSY    = busy_r;
    assign DIV_DONE    = done_r;
    assign DIV_Q       = q_r;
    assign DIV_R       = r_r;
    assign DIV_BY_ZERO = bz_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter with hand-computed expected results.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        DIV_START;
    logic        DIV_SIGNED;
    logic [31:0] DIVIDEND;
    logic [31:0] DIVISOR;
    logic        DIV_BUSY;
    logic        DIV_DONE;
    logic [31:0] DIV_Q;
    logic [31:0] DIV_R;
    logic        DIV_BY_ZERO;

    logic [31:0] st_rem;
    logic [31:0] st_quo;
    logic [31:0] st_dvs;
    logic [31:0] st_rem_next;
    logic [31:0] st_quo_next;

    int n_cmp;
    int n_bad;

    div_iter #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .DIV_START   (DIV_START),
        .DIV_SIGNED  (DIV_SIGNED),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .DIV_BUSY    (DIV_BUSY),
        .DIV_DONE    (DIV_DONE),
        .DIV_Q       (DIV_Q),
        .DIV_R       (DIV_R),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    div_step #(.WIDTH(32)) u_gold_step (
        .rem      (st_rem),
        .quo      (st_quo),
        .divisor  (st_dvs),
        .rem_next (st_rem_next),
        .quo_next (st_quo_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one division and wait for DONE. lat counts edges with the accept
    // edge as 1 (DONE expected at 34); busy_n counts samples with BUSY high.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n);
        @(negedge clk);
        DIV_SIGNED = sgn;
        DIVIDEND   = a;
        DIVISOR    = b;
        DIV_START  = 1'b1;
        @(posedge clk);
        #1;
        DIV_START = 1'b0;
        lat    = 1;
        busy_n = DIV_BUSY ? 1 : 0;
        while (!DIV_DONE && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (DIV_BUSY) busy_n++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        chk("reset_q", DIV_Q, 32'h0000_0000);
        chk("reset_r", DIV_R, 32'h0000_0000);
        chk("reset_busy", {31'd0, DIV_BUSY}, 32'd0);
        chk("reset_done", {31'd0, DIV_DONE}, 32'd0);
        chk("reset_bz", {31'd0, DIV_BY_ZERO}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_step;
        st_rem = 32'd5; st_quo = 32'h8000_0000; st_dvs = 32'd7;
        #1;
        chk("step1_rem", st_rem_next, 32'd4);
        chk("step1_quo", st_quo_next, 32'h0000_0001);
        st_rem = 32'd2; st_quo = 32'h4000_0000; st_dvs = 32'd7;
        #1;
        chk("step2_rem", st_rem_next, 32'd4);
        chk("step2_quo", st_quo_next, 32'h8000_0000);
        st_rem = 32'h8000_0000; st_quo = 32'h8000_0000; st_dvs = 32'hFFFF_FFFF;
        #1;
        chk("step3_rem", st_rem_next, 32'd2);
        chk("step3_quo", st_quo_next, 32'h0000_0001);
    endtask

    task automatic test_divu_basic;
        int lat, busy_n;
        do_div(1'b0, 32'd100, 32'd7, lat, busy_n);
        chk("divu_lat", lat, 32'd34);
        chk("divu_busy_cycles", busy_n, 32'd33);
        chk("divu_q", DIV_Q, 32'd14);
        chk("divu_r", DIV_R, 32'd2);
        chk("divu_bz", {31'd0, DIV_BY_ZERO}, 32'd0);
        @(posedge clk);
        #1;
        chk("divu_done_pulse", {31'd0, DIV_DONE}, 32'd0);
    endtask

    task automatic test_signed;
        int lat, busy_n;
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, busy_n);
        chk("div_negdvd_q", DIV_Q, 32'hFFFF_FFF2);
        chk("div_negdvd_r", DIV_R, 32'hFFFF_FFFE);
        do_div(1'b1, 32'd100, 32'hFFFF_FFF9, lat, busy_n);
        chk("div_negdvs_q", DIV_Q, 32'hFFFF_FFF2);
        chk("div_negdvs_r", DIV_R, 32'd2);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
        chk("div_ovf_lat", lat, 32'd34);
        chk("div_ovf_q", DIV_Q, 32'h8000_0000);
        chk("div_ovf_r", DIV_R, 32'h0000_0000);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
        chk("divu_small_q", DIV_Q, 32'h0000_0000);
        chk("divu_small_r", DIV_R, 32'h8000_0000);
    endtask

    task automatic test_div_by_zero;
        int lat, busy_n;
        do_div(1'b0, 32'h1234_5678, 32'd0, lat, busy_n);
        chk("dbz_lat", lat, 32'd34);
        chk("dbz_q", DIV_Q, 32'hFFFF_FFFF);
        chk("dbz_r", DIV_R, 32'h1234_5678);
        chk("dbz_flag", {31'd0, DIV_BY_ZERO}, 32'd1);
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, lat, busy_n);
        chk("dbz_s_q", DIV_Q, 32'hFFFF_FFFF);
        chk("dbz_s_r", DIV_R, 32'hFFFF_FFFB);
        chk("dbz_s_flag", {31'd0, DIV_BY_ZERO}, 32'd1);
    endtask

    task automatic test_ignore_start;
        int done_cnt, done_edge;
        logic [31:0] q_seen, r_seen;
        done_cnt = 0; done_edge = 0; q_seen = 32'd0; r_seen = 32'd0;
        @(negedge clk);
        DIV_SIGNED = 1'b0; DIVIDEND = 32'd1000; DIVISOR = 32'd10; DIV_START = 1'b1;
        @(posedge clk);
        #1;
        DIV_START = 1'b0;
        for (int e = 2; e <= 50; e++) begin
            @(posedge clk);
            #1;
            if (DIV_DONE) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_edge = e;
                    q_seen = DIV_Q;
                    r_seen = DIV_R;
                end
            end
            DIV_START = (e == 5 || e == 20);
            DIVIDEND  = 32'd7;
            DIVISOR   = 32'd3;
        end
        DIV_START = 1'b0;
        chk("ign_done_count", done_cnt, 32'd1);
        chk("ign_done_edge", done_edge, 32'd34);
        chk("ign_q", q_seen, 32'd100);
        chk("ign_r", r_seen, 32'd0);
        chk("ign_bz_cleared", {31'd0, DIV_BY_ZERO}, 32'd0);
    endtask

    task automatic test_back_to_back;
        int lat, busy_n;
        do_div(1'b0, 32'd50, 32'd6, lat, busy_n);
        chk("b2b_first_q", DIV_Q, 32'd8);
        chk("b2b_first_r", DIV_R, 32'd2);
        // Still in the DONE cycle: request the next division right away.
        DIVIDEND = 32'd81; DIVISOR = 32'd9; DIV_START = 1'b1;
        @(posedge clk);
        #1;
        DIV_START = 1'b0;
        chk("b2b_accept_busy", {31'd0, DIV_BUSY}, 32'd1);
        chk("b2b_hold_q", DIV_Q, 32'd8);
        chk("b2b_hold_r", DIV_R, 32'd2);
        lat = 1;
        while (!DIV_DONE && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_second_lat", lat, 32'd34);
        chk("b2b_second_q", DIV_Q, 32'd9);
        chk("b2b_second_r", DIV_R, 32'd0);
    endtask

    task automatic test_reset_mid;
        int lat, busy_n, done_cnt;
        done_cnt = 0;
        @(negedge clk);
        DIV_SIGNED = 1'b0; DIVIDEND = 32'd100; DIVISOR = 32'd7; DIV_START = 1'b1;
        @(posedge clk);
        #1;
        DIV_START = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rmid_q", DIV_Q, 32'd0);
        chk("rmid_r", DIV_R, 32'd0);
        chk("rmid_busy", {31'd0, DIV_BUSY}, 32'd0);
        chk("rmid_done", {31'd0, DIV_DONE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (DIV_DONE || DIV_BUSY) done_cnt++;
        end
        chk("rmid_no_done", done_cnt, 32'd0);
        do_div(1'b1, 32'd9, 32'd3, lat, busy_n);
        chk("rmid_fresh_lat", lat, 32'd34);
        chk("rmid_fresh_q", DIV_Q, 32'd3);
        chk("rmid_fresh_r", DIV_R, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        DIV_START  = 1'b0;
        DIV_SIGNED = 1'b0;
        DIVIDEND   = 32'd0;
        DIVISOR    = 32'd0;
        st_rem = 32'd0; st_quo = 32'd0; st_dvs = 32'd0;
        test_reset;
        test_step;
        test_divu_basic;
        test_signed;
        test_div_by_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
